// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Operation encodings are also used by the control decoder.
package pc_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC    = 3'd0;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd1;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
    localparam logic [OP_W-1:0] OP_RET    = 3'd4;
    localparam logic [OP_W-1:0] OP_HOLD   = 3'd5;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses for CALL/RET.
// The top entry is readable combinationally, so a RET right after a CALL needs no bubble.
module return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_dec;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    assign ptr_dec  = ptr - PTR_W'(1);
    assign top_data = mem[ptr_dec[IDX_W-1:0]];
    assign empty    = (ptr == '0);
    assign full     = (ptr == PTR_W'(STACK_DEPTH));

    // Pointer counts held entries; the caller never pushes when full or pops when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
        end else if (pop) begin
            ptr <= ptr_dec;
        end
    end

    // Entry storage needs no reset; slots above the pointer are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-address selection with a return-address stack.
// Stack misuse is absorbed as an increment and latched into sticky flags.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [OP_W-1:0]   next_ctl,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] offset,
    input  logic              cond,
    output logic [ADDR_W-1:0] address,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_br;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] top_data;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;

    assign addr_inc = address + ADDR_W'(1);
    assign addr_br  = address + offset;

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (addr_inc),
        .top_data  (top_data),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    // Decode the operation into the next address and stack/flag actions.
    always_comb begin
        next_addr = addr_inc;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (en) begin
            case (next_ctl)
                OP_JUMP: begin
                    next_addr = target;
                end
                OP_BRANCH: begin
                    if (cond) begin
                        next_addr = addr_br;
                    end
                end
                OP_CALL: begin
                    if (stack_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push      = 1'b1;
                        next_addr = target;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pop       = 1'b1;
                        next_addr = top_data;
                    end
                end
                OP_HOLD: begin
                    next_addr = address;
                end
                default: begin
                    next_addr = addr_inc;
                end
            endcase
        end
    end

    // Program counter register; frozen while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address <= RESET_ADDR;
        end else if (en) begin
            address <= next_addr;
        end
    end

    // Sticky stack-misuse flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test of pc_sequencer with hand-computed expected addresses.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] next_ctl;
    logic [7:0] target;
    logic [7:0] offset;
    logic       cond;
    logic [7:0] address;
    logic       stack_empty;
    logic       stack_full;
    logic       overflow;
    logic       underflow;

    int n_vec;
    int n_err;

    pc_sequencer #(
        .ADDR_W      (8),
        .STACK_DEPTH (4),
        .RESET_ADDR  (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .next_ctl    (next_ctl),
        .target      (target),
        .offset      (offset),
        .cond        (cond),
        .address     (address),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic [7:0] tgt,
                        input logic [7:0] off, input logic c);
        en       = 1'b1;
        next_ctl = op;
        target   = tgt;
        offset   = off;
        cond     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input int n);
        en       = 1'b0;
        next_ctl = OP_JUMP;
        target   = 8'hEE;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        en       = 1'b0;
        next_ctl = OP_INC;
        target   = 8'h00;
        offset   = 8'h00;
        cond     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", address, 8'h00);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_unf", underflow, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_addr", address, 8'h00);

        step(OP_INC, 8'h00, 8'h00, 1'b0);
        check("inc1", address, 8'h01);
        step(OP_INC, 8'h00, 8'h00, 1'b0);
        check("inc2", address, 8'h02);
        step(OP_INC, 8'h00, 8'h00, 1'b0);
        check("inc3", address, 8'h03);
        stall(2);
        check("stall", address, 8'h03);

        step(OP_JUMP, 8'h40, 8'h00, 1'b0);
        check("jump", address, 8'h40);
        step(OP_BRANCH, 8'h00, 8'hFE, 1'b1);
        check("br_taken", address, 8'h3E);
        step(OP_BRANCH, 8'h00, 8'hFE, 1'b0);
        check("br_not", address, 8'h3F);
        step(3'd6, 8'h77, 8'h00, 1'b0);
        check("rsvd6", address, 8'h40);
        step(3'd7, 8'h77, 8'h00, 1'b0);
        check("rsvd7", address, 8'h41);

        step(OP_JUMP, 8'h10, 8'h00, 1'b0);
        step(OP_CALL, 8'h80, 8'h00, 1'b0);
        check("call1", address, 8'h80);
        check("call1_emp", stack_empty, 1'b0);
        step(OP_CALL, 8'h90, 8'h00, 1'b0);
        check("call2", address, 8'h90);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("ret1", address, 8'h81);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("ret2", address, 8'h11);
        check("ret2_emp", stack_empty, 1'b1);

        step(OP_CALL, 8'hA0, 8'h00, 1'b0);
        step(OP_CALL, 8'hB0, 8'h00, 1'b0);
        step(OP_CALL, 8'hC0, 8'h00, 1'b0);
        check("c3_full", stack_full, 1'b0);
        step(OP_CALL, 8'h20, 8'h00, 1'b0);
        check("c4_addr", address, 8'h20);
        check("c4_full", stack_full, 1'b1);
        step(OP_CALL, 8'h55, 8'h00, 1'b0);
        check("ovf_addr", address, 8'h21);
        check("ovf_flag", overflow, 1'b1);
        step(OP_HOLD, 8'h99, 8'h00, 1'b1);
        check("hold_addr", address, 8'h21);
        check("ovf_sticky", overflow, 1'b1);
        check("hold_full", stack_full, 1'b1);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("pop4", address, 8'hC1);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("pop3", address, 8'hB1);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("pop2", address, 8'hA1);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("pop1", address, 8'h12);
        check("pop_emp", stack_empty, 1'b1);
        check("unf_clear", underflow, 1'b0);
        step(OP_JUMP, 8'h30, 8'h00, 1'b0);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("unf_addr", address, 8'h31);
        check("unf_flag", underflow, 1'b1);
        check("ovf_kept", overflow, 1'b1);

        step(OP_JUMP, 8'hFF, 8'h00, 1'b0);
        step(OP_INC, 8'h00, 8'h00, 1'b0);
        check("wrap_inc", address, 8'h00);
        step(OP_JUMP, 8'h02, 8'h00, 1'b0);
        step(OP_BRANCH, 8'h00, 8'hFC, 1'b1);
        check("wrap_br", address, 8'hFE);
        step(OP_JUMP, 8'hFF, 8'h00, 1'b0);
        step(OP_CALL, 8'h10, 8'h00, 1'b0);
        check("wrap_call", address, 8'h10);
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("wrap_ret", address, 8'h00);
        check("wrap_emp", stack_empty, 1'b1);

        step(OP_JUMP, 8'h50, 8'h00, 1'b0);
        step(OP_CALL, 8'h60, 8'h00, 1'b0);
        step(OP_CALL, 8'h70, 8'h00, 1'b0);
        check("pre_rst", address, 8'h70);
        next_ctl = OP_RET;
        #2;
        reset = 1'b1;
        #1;
        check("arst_addr", address, 8'h00);
        check("arst_emp", stack_empty, 1'b1);
        check("arst_full", stack_full, 1'b0);
        check("arst_ovf", overflow, 1'b0);
        check("arst_unf", underflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(OP_RET, 8'h00, 8'h00, 1'b0);
        check("post_ret", address, 8'h01);
        check("post_unf", underflow, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
